cache_port_arbiter: RTL
=======================

# cache_port_arbiter

Two-requester front end for the shared 64-bit data cache. It accepts load/store requests from VLIW slot 0 and slot 1 through valid/ready handshakes and grants the single cache port round-robin. It drives the cache enables for exactly one cycle per operation, captures the read data and returns a one-cycle response pulse to the owning slot. It sits between the slot load/store units and the cache, and is the only driver of the cache port.

## Interface
Parameters:
- ADDR_W, 16, request/cache address width (2 tag, 10 index, 4 offset).
- DATA_W, 64, data word width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  slot N (N = 0, 1) has a request.
- reqN_we  in  1  1 = store, 0 = load.
- reqN_addr  in  ADDR_W  request address.
- reqN_wdata  in  DATA_W  store data.
- reqN_ready  out  1  request accepted this cycle when valid & ready.
- rspN_valid  out  1  one-cycle completion pulse to slot N.
- rspN_rdata  out  DATA_W  load data; valid when rspN_valid is high after a load.
- cache_read_addr  out  ADDR_W  cache read address.
- cache_write_addr  out  ADDR_W  cache write address.
- cache_write_data  out  DATA_W  cache write data.
- cache_readEnable  out  1  cache read strobe.
- cache_writeEnable  out  1  cache write strobe.
- cache_read_data  in  DATA_W  cache read data; valid in the cycle after the strobe edge.
- stat_reads  out  CNT_W  count of accepted loads.
- stat_writes  out  CNT_W  count of accepted stores.

## Operation
- FSM states: IDLE, ISSUE, CAPT.
- IDLE: if any reqN_valid, compute a combinational grant and raise reqN_ready for the winner only. On the accept edge, latch addr, we, wdata and owner into op registers, update the round-robin pointer, increment stat_reads or stat_writes, and go to ISSUE. With no valid, stay in IDLE.
- Round-robin:
  - Single valid requester wins.
  - If both are valid, the requester not granted last wins.
  - The pointer resets to "last = 1", so slot 0 wins the first tie.
- ISSUE: cache_readEnable = !op_we and cache_writeEnable = op_we, decoded combinationally from state, so each is high for exactly this one cycle. cache_read_addr and cache_write_addr both carry op_addr on every operation, because the cache derives its index from the read address even on writes. cache_write_data = op_wdata. Next state is CAPT.
- CAPT: enables low, no ready.
  - Load: register cache_read_data into rsp<owner>_rdata on the exit edge.
  - Store: rspN_rdata holds its previous value.
  - Set rsp<owner>_valid on the exit edge; next state is IDLE.
- rspN_valid is a registered pulse, high for exactly one cycle. The two rsp pulses are never high together.
- reqN_ready is low in ISSUE and CAPT. Requests held there are neither dropped nor duplicated.
- Statistics counters wrap modulo 2^CNT_W, with no saturation.

## Timing
- Reset values:
  - FSM = IDLE, pointer = last 1.
  - All op registers, cache address/data outputs, rspN_rdata and stat counters = 0.
  - rspN_valid = 0, reqN_ready = 0 while rst is high, cache enables = 0.
- Reset mid-operation: on the next edge, state returns to IDLE, the in-flight op is discarded, no response is issued and counters clear. An enable already sampled by the cache is not undone.
- Latency: accept at edge E0 → ISSUE in cycle E0..E1 → cache acts at E1 → CAPT in E1..E2 → rsp pulse in E2..E3.
- Throughput: the next accept can happen at edge E3, so the sustained rate is one op per 3 cycles.
- A request arriving during ISSUE/CAPT waits for IDLE. Requesters must hold valid and fields stable until ready.
- reqN_ready depends combinationally on reqN_valid and state. There are no other combinational input-to-output paths.

## Test plan
- Single load: slot 0 reads 0x4A35 while the cache returns 0x1234_5678_9ABC_DEF0 → req0_ready for 1 cycle; cache_readEnable high for exactly 1 cycle with both addresses = 0x4A35; rsp0_valid 3 cycles after accept with rdata = 0x123456789ABCDEF0; stat_reads = 1.
- Store then load: slot 1 writes 0xDEAD_BEEF to 0x0010, then reads 0x0010 → one writeEnable pulse with write_data 0xDEADBEEF and both addresses 0x0010; rsp1_valid pulse with rdata unchanged; the following read returns 0xDEADBEEF; stat_writes = 1, stat_reads = 1.
- Contention: both slots hold valid continuously for 6 ops → grants alternate 0,1,0,1,0,1; ops accepted every 3 cycles; responses go to matching slots; the rsp pulses never overlap.
- Idle gaps and single requester: slot 1 alone issues 3 back-to-back loads → all 3 granted to slot 1 with no idle cycles between ops beyond the 3-cycle spacing.
- Reset in ISSUE: assert rst for 1 cycle while in ISSUE → no rsp pulse, enables low after the edge, stats = 0; the next request is served normally, with slot 0 winning the tie.
- Counter wrap: with CNT_W = 4, issue 17 loads → stat_reads reads 1.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// Bundle of the two slot request/response channels, the single cache port and the statistics outputs.
// The arbiter takes the slave view; the slot load/store units and the cache together form the master side.
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;

    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] cache_read_addr;
    logic [ADDR_W-1:0] cache_write_addr;
    logic [DATA_W-1:0] cache_write_data;
    logic              cache_readEnable;
    logic              cache_writeEnable;
    logic [DATA_W-1:0] cache_read_data;

    logic [CNT_W-1:0]  stat_reads;
    logic [CNT_W-1:0]  stat_writes;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output cache_read_data,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  cache_read_addr, cache_write_addr, cache_write_data,
        input  cache_readEnable, cache_writeEnable,
        input  stat_reads, stat_writes
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  cache_read_data,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output cache_read_addr, cache_write_addr, cache_write_data,
        output cache_readEnable, cache_writeEnable,
        output stat_reads, stat_writes
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin front end sharing one 64-bit cache port between two VLIW load/store slots.
// Each operation runs IDLE (accept) -> ISSUE (cache strobe) -> CAPT (capture), then pulses a response.
module cache_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    cache_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic              r_lastGrant;
    logic              r_opWe;
    logic              r_opOwner;
    logic [ADDR_W-1:0] r_opAddr;
    logic [DATA_W-1:0] r_opWdata;
    logic              r_rspValid0;
    logic              r_rspValid1;
    logic [DATA_W-1:0] r_rspRdata0;
    logic [DATA_W-1:0] r_rspRdata1;
    logic [CNT_W-1:0]  r_statReads;
    logic [CNT_W-1:0]  r_statWrites;

    logic              w_anyValid;
    logic              w_grant1;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic              w_readEn;
    logic              w_writeEn;
    logic              w_acceptWe;

    // On a tie the slot that did not win last time gets the port; ready is withheld during reset.
    always_comb begin
        w_nextState = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_readEn    = 1'b0;
        w_writeEn   = 1'b0;
        w_anyValid  = bus.req0_valid | bus.req1_valid;
        w_grant1    = bus.req1_valid & (~bus.req0_valid | ~r_lastGrant);
        case (r_state)
            IDLE: begin
                if (w_anyValid && !rst) begin
                    w_ready0    = ~w_grant1;
                    w_ready1    = w_grant1;
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                w_readEn    = ~r_opWe;
                w_writeEn   = r_opWe;
                w_nextState = CAPT;
            end
            CAPT: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_accept   = w_ready0 | w_ready1;
    assign w_acceptWe = w_grant1 ? bus.req1_we : bus.req0_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lastGrant  <= 1'b1;
            r_opWe       <= 1'b0;
            r_opOwner    <= 1'b0;
            r_opAddr     <= '0;
            r_opWdata    <= '0;
            r_rspValid0  <= 1'b0;
            r_rspValid1  <= 1'b0;
            r_rspRdata0  <= '0;
            r_rspRdata1  <= '0;
            r_statReads  <= '0;
            r_statWrites <= '0;
        end else begin
            r_state     <= w_nextState;
            r_rspValid0 <= 1'b0;
            r_rspValid1 <= 1'b0;
            if (w_accept) begin
                r_opWe      <= w_acceptWe;
                r_opOwner   <= w_grant1;
                r_opAddr    <= w_grant1 ? bus.req1_addr : bus.req0_addr;
                r_opWdata   <= w_grant1 ? bus.req1_wdata : bus.req0_wdata;
                r_lastGrant <= w_grant1;
                if (w_acceptWe) begin
                    r_statWrites <= r_statWrites + CNT_W'(1);
                end else begin
                    r_statReads <= r_statReads + CNT_W'(1);
                end
            end
            // Cache read data is valid during CAPT, so it is captured on the CAPT exit edge.
            if (r_state == CAPT) begin
                if (r_opOwner) begin
                    r_rspValid1 <= 1'b1;
                    if (!r_opWe) begin
                        r_rspRdata1 <= bus.cache_read_data;
                    end
                end else begin
                    r_rspValid0 <= 1'b1;
                    if (!r_opWe) begin
                        r_rspRdata0 <= bus.cache_read_data;
                    end
                end
            end
        end
    end

    // The cache indexes on the read address even for stores, so both addresses carry the op address.
    assign bus.req0_ready        = w_ready0;
    assign bus.req1_ready        = w_ready1;
    assign bus.rsp0_valid        = r_rspValid0;
    assign bus.rsp1_valid        = r_rspValid1;
    assign bus.rsp0_rdata        = r_rspRdata0;
    assign bus.rsp1_rdata        = r_rspRdata1;
    assign bus.cache_read_addr   = r_opAddr;
    assign bus.cache_write_addr  = r_opAddr;
    assign bus.cache_write_data  = r_opWdata;
    assign bus.cache_readEnable  = w_readEn;
    assign bus.cache_writeEnable = w_writeEn;
    assign bus.stat_reads        = r_statReads;
    assign bus.stat_writes       = r_statWrites;
endmodule
